// File: rtl/ddr2_wr_splitter_pkg.sv
// Shared constants and types for the DDR2 write splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr2_wr_splitter_pkg;

  // Default DDR2 geometry for the top-level parameters.
  localparam int DDR2_BA_BITS  = 2;
  localparam int DDR2_ROW_BITS = 14;
  localparam int DDR2_COL_BITS = 10;
  localparam int DDR2_DQ_BITS  = 16;

  // One beat carries two DDR columns.
  localparam int DDR2_BEATS_PER_ROW = 2 ** (DDR2_COL_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DATA,
    ST_WAITB,
    ST_RESP
  } state_t;

  function automatic logic [15:0] min3(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr2_wr_splitter_fifo.sv
// Synchronous first-word-fall-through FIFO for write data.
// Latency: push visible at dout/!empty one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk/rst_n, push+din, pop, dout (head), full, empty, count.
module ddr2_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      // Simultaneous push and pop leave the count unchanged.
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr2_wr_splitter.sv
// Splits user write bursts into row-safe, length-capped sub-bursts for ddr2_ctrl.
// Latency: AW accept -> m_awvalid 1 cycle; last m_bvalid -> s_bvalid 1 cycle; data FWFT 1 cycle.
// Backpressure: s_wready drops on FIFO full / burst complete; FSM holds on m_awready, m_wready, FIFO empty.
// Ports: s_aw*/s_w*/s_b* user slave side, m_aw*/m_w*/m_b* controller master side, init_end gates new bursts.
module ddr2_wr_splitter
  import ddr2_wr_splitter_pkg::*;
#(
  parameter int BA_BITS    = DDR2_BA_BITS,
  parameter int ROW_BITS   = DDR2_ROW_BITS,
  parameter int COL_BITS   = DDR2_COL_BITS,
  parameter int DATA_W     = DDR2_DQ_BITS * 2,
  parameter int MAX_BEATS  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 init_end,
  input  logic                                 s_awvalid,
  output logic                                 s_awready,
  input  logic [BA_BITS+ROW_BITS+COL_BITS-1:0] s_awaddr,
  input  logic [7:0]                           s_awlen,
  input  logic                                 s_wvalid,
  output logic                                 s_wready,
  input  logic [DATA_W-1:0]                    s_wdata,
  input  logic                                 s_wlast,
  output logic                                 s_bvalid,
  input  logic                                 s_bready,
  output logic                                 m_awvalid,
  input  logic                                 m_awready,
  output logic [BA_BITS+ROW_BITS+COL_BITS-1:0] m_awaddr,
  output logic [7:0]                           m_awlen,
  output logic                                 m_wvalid,
  input  logic                                 m_wready,
  output logic [DATA_W-1:0]                    m_wdata,
  output logic                                 m_wlast,
  input  logic                                 m_bvalid,
  output logic                                 m_bready
);
  localparam int AW    = BA_BITS + ROW_BITS + COL_BITS;
  localparam int CW    = COL_BITS + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q, state_d;
  logic [BA_BITS-1:0]  ba_q, ba_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [8:0]          rem_q, rem_d, total_q, total_d, wr_cnt_q, wr_cnt_d;
  logic [7:0]          len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic                awready_q, awready_d;

  logic                aw_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_dout;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [CW-1:0]       col_sum;
  logic [ROW_BITS:0]   row_inc;
  logic [8:0]          rem_new;
  logic [COL_BITS-1:0] col_new;
  logic                unused_in;

  // Beats until end of row, capped by remaining beats and MAX_BEATS.
  function automatic logic [7:0] calc_len(input logic [8:0] rem,
                                          input logic [COL_BITS-1:0] col);
    logic [CW-1:0] row_left;
    row_left = ({1'b1, {COL_BITS{1'b0}}} - {1'b0, col}) >> 1;
    return 8'(min3(16'(rem), 16'(row_left), 16'(MAX_BEATS)));
  endfunction

  // init_end gates the registered ready so a falling init_end blocks new bursts at once.
  assign s_awready = awready_q & init_end;
  assign aw_hs     = s_awvalid & s_awready;
  assign s_wready  = (state_q != ST_IDLE) & ~fifo_full & (wr_cnt_q < total_q);
  assign s_bvalid  = (state_q == ST_RESP);
  assign fifo_push = s_wvalid & s_wready;

  assign m_awvalid = (state_q == ST_ISSUE);
  assign m_awaddr  = m_awvalid ? {ba_q, row_q, col_q} : '0;
  assign m_awlen   = m_awvalid ? (len_q - 8'd1) : '0;
  assign m_wvalid  = (state_q == ST_DATA) & ~fifo_empty;
  assign m_wdata   = m_wvalid ? fifo_dout : '0;
  assign m_wlast   = m_wvalid & (beat_cnt_q == len_q - 8'd1);
  assign m_bready  = 1'b1;
  assign fifo_pop  = m_wvalid & m_wready;

  // User wlast is not trusted; the accepted-beat count ends the burst.
  assign unused_in = s_wlast ^ (^fifo_cnt);

  assign col_sum = {1'b0, col_q} + CW'({len_q, 1'b0});
  assign row_inc = {1'b0, row_q} + (ROW_BITS+1)'(1);
  assign rem_new = {1'b0, s_awlen} + 9'd1;
  assign col_new = s_awaddr[COL_BITS-1:0] & ~COL_BITS'(3);

  ddr2_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (s_wdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    ba_d       = ba_q;
    row_d      = row_q;
    col_d      = col_q;
    rem_d      = rem_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    total_d    = total_q;
    wr_cnt_d   = fifo_push ? (wr_cnt_q + 9'd1) : wr_cnt_q;
    awready_d  = (state_q == ST_IDLE) & init_end & ~aw_hs;

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          ba_d     = s_awaddr[AW-1 -: BA_BITS];
          row_d    = s_awaddr[COL_BITS +: ROW_BITS];
          col_d    = col_new;
          rem_d    = rem_new;
          total_d  = rem_new;
          wr_cnt_d = '0;
          len_d    = calc_len(rem_new, col_new);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_awready) begin
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fifo_pop) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == len_q - 8'd1) state_d = ST_WAITB;
        end
      end
      ST_WAITB: begin
        if (m_bvalid) begin
          rem_d = rem_q - {1'b0, len_q};
          col_d = col_sum[COL_BITS-1:0];
          // Sub-bursts never pass the row end, so a carry means col wrapped to 0.
          if (col_sum[COL_BITS]) begin
            row_d = row_inc[ROW_BITS-1:0];
            if (row_inc[ROW_BITS]) ba_d = ba_q + BA_BITS'(1);
          end
          len_d   = calc_len(rem_d, col_d);
          state_d = (rem_d != '0) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (s_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      total_q    <= '0;
      wr_cnt_q   <= '0;
      awready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ba_q       <= ba_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      total_q    <= total_d;
      wr_cnt_q   <= wr_cnt_d;
      awready_q  <= awready_d;
    end
  end

endmodule
